// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with integer clocks-per-bit divider.
// Define UART_TX_PARITY_EN to append an even parity bit (8E1).
module uart_transmitter #(
  parameter int CLK_FREQ  = 1000,
  parameter int BAUD_RATE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] datain,
  input  logic       data_valid,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

`ifdef UART_TX_PARITY_EN
  localparam int SW = 11;
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;
`else
  localparam int SW = 10;
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [SW-1:0]   shift_reg, shift_reg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            bit_done;
  logic [SW-1:0]   shifted;

  assign bit_done = (cnt_q == CNT_MAX);
  assign shifted  = {1'b1, shift_reg[SW-1:1]};
  assign tx       = tx_q;
  assign tx_busy  = busy_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_reg_d = shift_reg;
    tx_d        = tx_q;
    busy_d      = busy_q;
    cnt_d       = bit_done ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_valid) begin
`ifdef UART_TX_PARITY_EN
          shift_reg_d = {1'b1, ^datain, datain, 1'b0};
`else
          shift_reg_d = {1'b1, datain, 1'b0};
`endif
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          shift_reg_d = shifted;
          tx_d        = shifted[0];
          idx_d       = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        // shift_reg[0] always holds the bit currently on the line
        if (bit_done) begin
          shift_reg_d = shifted;
          tx_d        = shifted[0];
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          shift_reg_d = shifted;
          tx_d        = shifted[0];
          state_d     = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_reg <= '1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_reg <= shift_reg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level reference model of the
// serial waveform, checked bit period by bit period.
module tb_uart_transmitter;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 10;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       data_valid = 1'b0;
  logic       tx;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;

  uart_transmitter #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .datain    (datain),
    .data_valid(data_valid),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  logic exp_bits [0:10];
  logic [10:0] exp_sr;

  function automatic void build_model(input logic [7:0] d);
    int par;
    par = 0;
    for (int i = 0; i < 8; i++) par = par ^ ((d >> i) & 1);
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = ((d >> i) & 1) != 0;
    if (FB == 11) exp_bits[9] = (par != 0);
    exp_bits[FB-1] = 1'b1;
    exp_sr = 11'((1 << (FB - 1)) | (d << 1));
    if (FB == 11) exp_sr = exp_sr | 11'(par << 9);
  endfunction

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    datain     = d;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after the edge that samples data_valid.
  task automatic check_frame(input logic [7:0] d, input bit keep_valid,
                             input logic [7:0] mid_d, input string name);
    bit bad;
    bit busy_bad;
    logic got;
    build_model(d);
    checks++;
    if (dut.shift_reg !== exp_sr[FB-1:0]) begin
      failures++;
      $display("FAIL %s load shift_reg got=%h exp=%h", name,
               dut.shift_reg, exp_sr[FB-1:0]);
    end
    busy_bad = 1'b0;
    for (int b = 0; b < FB; b++) begin
      bad = 1'b0;
      got = exp_bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (tx !== exp_bits[b] && !bad) begin
          bad = 1'b1;
          got = tx;
        end
        if (tx_busy !== 1'b1) busy_bad = 1'b1;
        if (b == 0 && c == 0 && !keep_valid) data_valid = 1'b0;
        if (b == 4 && c == 0) datain = mid_d;
        @(posedge clk);
        #1;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d tx got=%b exp=%b", name, b, got,
                 exp_bits[b]);
      end
    end
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL %s tx_busy dropped inside frame got=0 exp=1", name);
    end
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s frame end tx=%b busy=%b exp tx=1 busy=0", name,
               tx, tx_busy);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 ||
          dut.shift_reg !== {FB{1'b1}}) begin
        failures++;
        $display("FAIL reset tx=%b busy=%b sr=%h exp tx=1 busy=0 sr=all1",
                 tx, tx_busy, dut.shift_reg);
      end
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy);
    end
  endtask

  task automatic test_single_frame();
    start_frame(8'h55);
    check_frame(8'h55, 1'b0, 8'h55, "frame55");
  endtask

  task automatic test_data_hold();
    start_frame(8'hA3);
    check_frame(8'hA3, 1'b0, 8'hFF, "hold_a3");
  endtask

  task automatic test_parity_one();
    start_frame(8'h01);
    check_frame(8'h01, 1'b0, 8'h01, "frame01");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] m;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      m = 8'($urandom);
      start_frame(d);
      check_frame(d, 1'b0, m, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d2;
    start_frame(8'h00);
    check_frame(8'h00, 1'b1, 8'h00, "b2b_0");
    // Idle cycle sampled above; valid still high, next edge restarts.
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b restart tx=%b busy=%b exp tx=0 busy=1",
               tx, tx_busy);
    end
    check_frame(8'h00, 1'b1, 8'h00, "b2b_1");
    d2 = 8'($urandom);
    datain = d2;
    @(posedge clk);
    #1;
    check_frame(d2, 1'b0, d2, "b2b_2");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom);
    start_frame(d);
    data_valid = 1'b0;
    repeat (4 * CPB + CPB / 2 - 1) @(posedge clk);
    #1;
    build_model(d);
    checks++;
    if (tx !== exp_bits[4] || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort tx=%b busy=%b exp tx=%b busy=1",
               tx, tx_busy, exp_bits[4]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy);
    end
    repeat (2 * CPB) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_abort tx=%b busy=%b exp tx=1 busy=0",
               tx, tx_busy);
    end
    start_frame(8'h3C);
    check_frame(8'h3C, 1'b0, 8'h3C, "after_abort");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_data_hold();
    test_parity_one();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
